instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front end of the vector CPU, sitting between `pc_control_unit` and instruction memory. It fetches the word at `PCNext` from a req/ack memory port and presents it to the decoder with a valid/ready handshake. When the decoder accepts the word, it pulses `Advance` so `pc_control_unit` commits the next PC. There is no prefetch, because branch resolution (JMP/JEQ/JLT) depends on flags from the instruction being executed.

## Interface
- `ADDR_W`, default 32: instruction address width.
- `DATA_W`, default 32: instruction width.
- `TIMEOUT`, default 255: number of REQ cycles without `MemAck` before a fault is declared.

- `clk`  in  1  system clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level signal; fetching runs while high.
- `EndFlag`  in  1  program-end indication from `pc_control_unit`.
- `PCNext`  in  ADDR_W  next instruction address from `pc_control_unit`; changes only on the edge after `Advance`.
- `Advance`  out  1  one-cycle pulse; `pc_control_unit` commits the next PC at this edge.
- `MemReq`  out  1  memory read request.
- `MemAddr`  out  ADDR_W  read address; equals `PCNext` while `MemReq`=1, otherwise 0.
- `MemAck`  in  1  read data valid this cycle.
- `MemData`  in  DATA_W  read data.
- `Instr`  out  DATA_W  fetched instruction.
- `InstrValid`  out  1  `Instr` is valid.
- `InstrReady`  in  1  decoder accepts `Instr`.
- `FetchPC`  out  ADDR_W  address from which `Instr` was fetched.
- `Fault`  out  1  sticky memory-timeout flag.

## Operation
- States:
  - IDLE: no request outstanding.
  - REQ: memory request outstanding.
  - HOLD: instruction presented to the decoder.
  - HALT: program ended.
  - FAULT: memory timed out.
- IDLE:
  - `start`=1 and `EndFlag`=0 → REQ.
  - `EndFlag`=1 → HALT.
- REQ:
  - `MemReq`=1; `MemAddr`=`PCNext` (combinational, stable because no `Advance` is pending).
  - On `MemAck`: register `Instr`<=`MemData`, `FetchPC`<=`PCNext`, set `InstrValid`; → HOLD.
  - A request is never abandoned: a `start` drop during REQ still completes the transaction.
- Watchdog in REQ:
  - Counts cycles with `MemAck`=0; cleared on entry to REQ.
  - Count reaching `TIMEOUT` → FAULT, with `MemReq` dropped at that edge.
- HOLD:
  - `InstrValid`=1; `Instr` and `FetchPC` stay stable until the handshake.
  - Handshake (`InstrValid`=1 and `InstrReady`=1): `Advance`=1 for exactly that cycle; `InstrValid` clears at the edge.
  - Next state after the handshake: HALT if `EndFlag`=1; else IDLE if `start`=0; else REQ.
- HALT: `MemReq`=0, `InstrValid`=0. Exit only via reset.
- FAULT: `Fault`=1, `MemReq`=0, `InstrValid`=0. Exit only via reset.
- `EndFlag` seen in REQ has no effect until after the handshake: the in-flight instruction is always delivered.
- `MemAck` outside REQ is ignored.

## Timing
- Reset (asynchronous, immediate, including mid-transaction):
  - State = IDLE.
  - `MemReq`, `Advance`, `InstrValid` and `Fault` = 0.
  - `Instr` and `FetchPC` = 0.
  - Watchdog = 0.
- Latency: `MemAck` at edge N → `InstrValid`=1 from N.
- Zero-wait memory with an always-ready decoder gives 1 instruction per 2 cycles (REQ, HOLD).
- `Advance` and a new `MemReq` never occur in the same cycle.
- `PCNext` is sampled only in REQ, i.e. one or more cycles after the `Advance` edge.
- Watchdog counter width is `$clog2(TIMEOUT+1)`.
  - `MemAck` in the same cycle the count reaches `TIMEOUT`: the ack wins, giving HOLD and no fault.

## Structure
- Package `vcpu_fetch_pkg`:
  - `fetch_state_t` enum: IDLE, REQ, HOLD, HALT, FAULT.
  - `ADDR_W` and `DATA_W` defaults.
- Sub-module `fetch_watchdog`:
  - Inputs: `clk`, `reset`, `clear`, `enable`.
  - Output: `expired`.
  - Parameterized by `TIMEOUT`.
- FSM and output registers live in `instr_fetch_unit`.

## Test plan
- Zero-wait fetch: reset low→high, `start`=1, `PCNext`=0x4, `MemAck` asserted whenever `MemReq`=1 with `MemData`=0x65000007, `InstrReady`=1 → `MemAddr`=0x4, then `Instr`=0x65000007 and `FetchPC`=0x4, one `Advance` pulse, a new `MemReq` 2 cycles after the first.
- Wait states and backpressure: `MemAck` delayed 3 cycles and `InstrReady` held low 4 cycles, `MemData`=0xC0000050 → `MemReq` and `MemAddr` stable throughout, `Instr` held stable, exactly one `Advance`.
- Branch redirect: `PCNext` changes from 0x8 to 0x50 on the edge after `Advance` → next `MemAddr`=0x50.
- End of program: `EndFlag`=1 raised while in REQ → current instruction still delivered, then HALT, no further `MemReq` even with `start`=1.
- Timeout: `TIMEOUT`=4, `MemAck` never asserted → `Fault`=1 after 4 REQ cycles, `MemReq`=0; `MemAck` arriving exactly at cycle 4 → HOLD, `Fault`=0.
- Async reset while in HOLD → `InstrValid`, `MemReq` and `Fault` drop immediately; fetch restarts from `PCNext` after release.

Source files
------------

// File: rtl/vcpu_fetch_pkg.sv
// Shared types and default widths for the vector CPU instruction fetch front end.
package vcpu_fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    HALT  = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// Memory-response watchdog: counts enabled cycles and flags the cycle whose count reaches TIMEOUT.
module fetch_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  MAX   = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  // expired marks the enabled cycle that would take the count to TIMEOUT
  assign expired = enable && (r_count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Non-prefetching instruction fetch: one memory read per PC, handed to the decoder by valid/ready.
module instr_fetch_unit
  import vcpu_fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int DATA_W  = FETCH_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              EndFlag,
  input  logic [ADDR_W-1:0] PCNext,
  output logic              Advance,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] Instr,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [ADDR_W-1:0] FetchPC,
  output logic              Fault
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_valid;
  logic              r_fault;
  logic              w_capture;
  logic              w_handshake;
  logic              w_to_fault;
  logic              w_in_req;
  logic              w_wd_clear;
  logic              w_wd_enable;
  logic              w_wd_expired;

  assign w_in_req    = (r_state == REQ);
  assign w_wd_clear  = !w_in_req;
  assign w_wd_enable = w_in_req && !MemAck;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );

  // PCNext cannot move while REQ is held, so the address is driven straight through
  assign MemReq     = w_in_req;
  assign MemAddr    = w_in_req ? PCNext : '0;
  assign Advance    = w_handshake;
  assign Instr      = r_instr;
  assign FetchPC    = r_fetch_pc;
  assign InstrValid = r_valid;
  assign Fault      = r_fault;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    w_to_fault  = 1'b0;
    case (r_state)
      IDLE: begin
        if (EndFlag) begin
          w_state_nxt = HALT;
        end else if (start) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        // an ack in the expiring cycle still wins over the timeout
        if (MemAck) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end else if (w_wd_expired) begin
          w_to_fault  = 1'b1;
          w_state_nxt = FAULT;
        end
      end
      HOLD: begin
        if (InstrReady) begin
          w_handshake = 1'b1;
          if (EndFlag) begin
            w_state_nxt = HALT;
          end else if (!start) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = REQ;
          end
        end
      end
      HALT:    w_state_nxt = HALT;
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr    <= '0;
      r_fetch_pc <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_instr    <= MemData;
        r_fetch_pc <= PCNext;
        r_valid    <= 1'b1;
      end else if (w_handshake) begin
        r_valid    <= 1'b0;
      end
      if (w_to_fault) begin
        r_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory/decoder/PC models drive it, a monitor checks delivered words.
module tb_instr_fetch_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          start      = 1'b0;
  logic          EndFlag    = 1'b0;
  logic [AW-1:0] PCNext     = '0;
  logic          MemAck     = 1'b0;
  logic [DW-1:0] MemData    = '0;
  logic          InstrReady = 1'b0;
  logic          Advance;
  logic          MemReq;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] Instr;
  logic          InstrValid;
  logic [AW-1:0] FetchPC;
  logic          Fault;

  instr_fetch_unit #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .EndFlag    (EndFlag),
    .PCNext     (PCNext),
    .Advance    (Advance),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemAck     (MemAck),
    .MemData    (MemData),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .FetchPC    (FetchPC),
    .Fault      (Fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  logic [AW-1:0] pc_list[$];
  int            n_checks  = 0;
  int            n_fail    = 0;
  int            delivered = 0;

  // stimulus knobs
  int            lat_min = 0, lat_max = 0, ready_delay = 0;
  bit            ack_never = 0, ready_rand = 0, start_rand = 0, stray_ack = 0;
  bit            sb_on = 1, fixed_en = 0, redirect_rand = 0;
  logic [DW-1:0] fixed_data = '0;
  logic [DW-1:0] salt = '0;

  // memory / decoder / pc model state
  bit            in_req = 0, adv_seen = 0;
  int            req_cyc = 0, lat = 0, hold_cyc = 0;

  // monitor history
  logic          mon_pv = 1'b0, mon_phs = 1'b0;
  logic [DW-1:0] mon_pi = '0;
  logic [AW-1:0] mon_pf = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (fixed_en) return fixed_data;
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Every PC value handed to the fetch unit is fetched exactly once, in order.
  task automatic set_pc(input logic [AW-1:0] pc);
    exp_t e;
    PCNext = pc;
    if (sb_on) begin
      e.pc   = pc;
      e.data = mem_word(pc);
      sb_q.push_back(e);
    end
  endtask

  task automatic do_reset(input logic [AW-1:0] pc);
    reset = 1'b0;
    sb_q.delete();
    pc_list.delete();
    in_req     = 0;
    adv_seen   = 0;
    hold_cyc   = 0;
    EndFlag    = 1'b0;
    MemAck     = 1'b0;
    InstrReady = 1'b0;
    set_pc(pc);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (adv_seen) begin
      adv_seen = 0;
      if (pc_list.size() > 0) set_pc(pc_list.pop_front());
      else if (redirect_rand && ($urandom_range(0, 3) == 0)) set_pc(AW'($urandom_range(0, 1023) * 4));
      else set_pc(PCNext + 32'd4);
    end
    if (start_rand) start = ($urandom_range(0, 7) != 0);
    #1;
    if (MemReq) begin
      if (!in_req) begin
        in_req  = 1;
        req_cyc = 0;
        lat     = ack_never ? -1 : int'($urandom_range(lat_max, lat_min));
      end else begin
        req_cyc++;
      end
      MemAck  = (lat >= 0) && (req_cyc == lat);
      MemData = MemAck ? mem_word(MemAddr) : DW'($urandom());
    end else begin
      in_req  = 0;
      MemAck  = stray_ack && ($urandom_range(0, 1) == 1);
      MemData = DW'($urandom());
    end
    if (InstrValid) begin
      hold_cyc++;
      InstrReady = ready_rand ? ($urandom_range(0, 1) == 1) : (hold_cyc > ready_delay);
    end else begin
      hold_cyc   = 0;
      InstrReady = ($urandom_range(0, 1) == 1);
    end
    #2;
    if (Advance) adv_seen = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        mon_pv  = 1'b0;
        mon_phs = 1'b0;
      end else begin
        check("memaddr", 64'(MemAddr), 64'(MemReq ? PCNext : AW'(0)));
        check("advance", 64'(Advance), 64'(InstrValid & InstrReady));
        check("adv_req_excl", 64'(Advance & MemReq), 64'(0));
        if (InstrValid && mon_pv && !mon_phs) begin
          check("instr_stable", 64'(Instr), 64'(mon_pi));
          check("fetchpc_stable", 64'(FetchPC), 64'(mon_pf));
        end
        if (InstrValid && InstrReady) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got fetchpc=0x%0h instr=0x%0h expected no delivery", FetchPC, Instr);
          end else begin
            e = sb_q.pop_front();
            check("sb_fetchpc", 64'(FetchPC), 64'(e.pc));
            check("sb_instr", 64'(Instr), 64'(e.data));
            delivered++;
          end
        end
        mon_pv  = InstrValid;
        mon_phs = InstrValid && InstrReady;
        mon_pi  = Instr;
        mon_pf  = FetchPC;
      end
    end
  end

  initial begin : guard
    #1000000;
    $display("FAIL sim_timeout: got no end expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int   first, second, advs, reqc, holdc, d0;
    logic prev_req;
    salt = DW'($urandom());

    // asynchronous reset values
    #2;
    reset = 1'b0;
    #1;
    check("rst_memreq", 64'(MemReq), 64'(0));
    check("rst_memaddr", 64'(MemAddr), 64'(0));
    check("rst_advance", 64'(Advance), 64'(0));
    check("rst_valid", 64'(InstrValid), 64'(0));
    check("rst_fault", 64'(Fault), 64'(0));
    check("rst_instr", 64'(Instr), 64'(0));
    check("rst_fetchpc", 64'(FetchPC), 64'(0));

    // zero-wait fetch
    fixed_en = 1; fixed_data = 32'h65000007; lat_min = 0; lat_max = 0; ready_delay = 0;
    start = 1'b1;
    do_reset(32'h4);
    first = -1; second = -1; advs = 0; prev_req = 1'b0;
    for (int i = 0; i < 12 && second < 0; i++) begin
      cycle();
      if (MemReq && !prev_req) begin
        if (first < 0) begin
          first = i;
          check("t1_first_addr", 64'(MemAddr), 64'(32'h4));
        end else begin
          second = i;
        end
      end
      if (Advance && second < 0) advs++;
      prev_req = MemReq;
    end
    check("t1_req_spacing", 64'(second - first), 64'(2));
    check("t1_adv_count", 64'(advs), 64'(1));

    // wait states and decoder backpressure
    fixed_data = 32'hC0000050; lat_min = 3; lat_max = 3; ready_delay = 4;
    do_reset(32'h10);
    advs = 0; reqc = 0; holdc = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (advs == 0) begin
        if (MemReq) reqc++;
        if (InstrValid) holdc++;
      end
      if (Advance) advs++;
    end
    check("t2_req_cycles", 64'(reqc), 64'(4));
    check("t2_hold_cycles", 64'(holdc), 64'(5));
    check("t2_adv_count", 64'(advs), 64'(1));

    // branch redirect
    fixed_en = 0; lat_min = 0; lat_max = 0; ready_delay = 0;
    do_reset(32'h8);
    pc_list.push_back(32'h50);
    first = -1; second = -1; prev_req = 1'b0;
    for (int i = 0; i < 12 && second < 0; i++) begin
      cycle();
      if (MemReq && !prev_req) begin
        if (first < 0) first = i;
        else begin
          second = i;
          check("t3_redirect_addr", 64'(MemAddr), 64'(32'h50));
        end
      end
      prev_req = MemReq;
    end
    check("t3_redirect_seen", 64'(second > 0), 64'(1));

    // end of program raised mid-request
    lat_min = 2; lat_max = 2;
    do_reset(32'h20);
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (MemReq) break;
    end
    check("t4_in_req", 64'(MemReq), 64'(1));
    EndFlag = 1'b1; sb_on = 0;
    advs = 0; reqc = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (Advance) advs++;
      if (advs > 0 && MemReq) reqc++;
    end
    check("t4_adv_count", 64'(advs), 64'(1));
    check("t4_req_after_halt", 64'(reqc), 64'(0));
    check("t4_valid_halt", 64'(InstrValid), 64'(0));

    // timeout with no acknowledge
    ack_never = 1;
    do_reset(32'h60);
    reqc = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (MemReq) reqc++;
    end
    check("t5_req_cycles", 64'(reqc), 64'(TO));
    check("t5_fault", 64'(Fault), 64'(1));
    check("t5_memreq", 64'(MemReq), 64'(0));
    check("t5_valid", 64'(InstrValid), 64'(0));
    stray_ack = 1;
    repeat (6) cycle();
    check("t5_fault_sticky", 64'(Fault), 64'(1));
    check("t5_memreq_sticky", 64'(MemReq), 64'(0));
    stray_ack = 0;

    // acknowledge in the expiring cycle
    ack_never = 0; sb_on = 1; lat_min = TO - 1; lat_max = TO - 1;
    do_reset(32'h64);
    advs = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (Advance) advs++;
    end
    check("t5b_adv_count", 64'(advs), 64'(1));
    check("t5b_no_fault", 64'(Fault), 64'(0));

    // asynchronous reset while holding an instruction
    lat_min = 0; lat_max = 0; ready_delay = 1000;
    do_reset(32'h30);
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (InstrValid) break;
    end
    check("t6_in_hold", 64'(InstrValid), 64'(1));
    reset = 1'b0;
    #1;
    check("t6_valid_drop", 64'(InstrValid), 64'(0));
    check("t6_memreq_drop", 64'(MemReq), 64'(0));
    check("t6_fault_drop", 64'(Fault), 64'(0));
    check("t6_instr_clr", 64'(Instr), 64'(0));
    check("t6_fetchpc_clr", 64'(FetchPC), 64'(0));
    ready_delay = 0;
    do_reset(32'h40);
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (MemReq) break;
    end
    check("t6_restart_addr", 64'(MemAddr), 64'(32'h40));
    d0 = delivered;
    for (int i = 0; i < 10 && delivered == d0; i++) cycle();
    check("t6_restart_delivered", 64'(delivered - d0), 64'(1));

    // randomized traffic
    lat_min = 0; lat_max = TO - 1; ready_rand = 1; start_rand = 1; stray_ack = 1; redirect_rand = 1;
    do_reset(32'h100);
    d0 = delivered;
    for (int i = 0; i < 3000 && (delivered - d0) < 60; i++) cycle();
    check("t7_delivered", 64'((delivered - d0) >= 60), 64'(1));
    check("t7_no_fault", 64'(Fault), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
